// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S APB register block.
// Latency: n/a (types only).
// Backpressure: n/a.
package i2s_pkg;

    typedef enum logic {
        RATE_44K1 = 1'b0,
        RATE_48K  = 1'b1
    } rate_e;

    typedef enum logic [1:0] {
        WS_16   = 2'd0,
        WS_24   = 2'd1,
        WS_32   = 2'd2,
        WS_RSVD = 2'd3
    } wsize_e;

    typedef enum logic {
        FS_16 = 1'b0,
        FS_32 = 1'b1
    } fsize_e;

    typedef enum logic [1:0] {
        STD_I2S  = 2'd0,
        STD_MSB  = 2'd1,
        STD_LSB  = 2'd2,
        STD_RSVD = 2'd3
    } std_e;

    typedef enum logic [1:0] {
        MODE_ST = 2'd0,
        MODE_SR = 2'd1,
        MODE_MT = 2'd2,
        MODE_MR = 2'd3
    } mode_e;

    typedef struct packed {
        logic   soft_rst;
        logic   stop;
        logic   mute;
        mode_e  mode;
        std_e   std;
        logic   mclk_en;
        fsize_e frame;
        wsize_e wsize;
        rate_e  rate;
        logic   stereo;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } apb_state_e;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_TXDATA   = 8'h08;
    localparam logic [7:0] OFF_RXDATA   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h10;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h14;

    localparam int IRQ_TX_OVER  = 0;
    localparam int IRQ_RX_UNDER = 1;
    localparam int IRQ_RX_AVAIL = 2;
    localparam int IRQ_W        = 3;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB handshake sequencer with bounded wait states for a full Tx path.
// Latency: pready in the first penable cycle unless stalled; stall ends on tx_ready or timeout.
// Backpressure: stall holds pready low for at most TIMEOUT cycles.
module apb_slave_fsm
    import i2s_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic psel,
    input  logic penable,
    input  logic stall,
    input  logic tx_ready,
    output logic pready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    apb_state_e      state;
    apb_state_e      state_nxt;
    logic [CW-1:0]   cnt;
    logic            expired;

    assign expired = (cnt == '0);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            // counter holds the number of wait cycles still allowed after the current one
            if (state == ST_ACCESS && state_nxt == ST_WAIT) begin
                cnt <= CW'(TIMEOUT - 1);
            end else if (state == ST_WAIT && !expired) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (psel && !penable) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = (psel && penable && stall) ? ST_WAIT : ST_IDLE;
            ST_WAIT:   if (tx_ready || expired) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pready = 1'b0;
        if (!preset) begin
            case (state)
                ST_ACCESS: pready = psel & penable & !stall;
                ST_WAIT:   pready = tx_ready | expired;
                default:   pready = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/i2s_apb_regs.sv
// APB register file for the I2S core: control, status, Tx/Rx data windows, interrupts.
// Latency: zero wait states except a TXDATA write while the Tx FIFO is full.
// Backpressure: full Tx FIFO stalls the APB transfer up to TIMEOUT cycles, then errors.
module i2s_apb_regs
    import i2s_pkg::*;
#(
    parameter int DW            = 32,
    parameter int AW            = 8,
    parameter int STALL_ON_FULL = 1,
    parameter int TIMEOUT       = 16
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output ctrl_t         ctrl,
    output logic          soft_rst,
    output logic          irq
);

    localparam int WA = AW - 2;

    logic [WA-1:0]    widx;
    logic             is_ctrl, is_stat, is_tx, is_rx, is_ien, is_ist;
    logic             wr_tx, rd_rx, wr_ctrl, wsize_bad, dec_err, err_cond;
    logic             stall, done, ok, wr_ok, rd_ok, ctrl_we;
    ctrl_t            ctrl_q, ctrl_nxt;
    logic [IRQ_W-1:0] irq_en_q, irq_stat_q, irq_set, irq_clr;
    logic             rx_valid_q, irq_q;
    logic             unused_bits;

    assign unused_bits = ^{paddr[1:0], pwdata[DW-1:13]};

    assign widx    = paddr[AW-1:2];
    assign is_ctrl = (widx == WA'(OFF_CTRL >> 2));
    assign is_stat = (widx == WA'(OFF_STATUS >> 2));
    assign is_tx   = (widx == WA'(OFF_TXDATA >> 2));
    assign is_rx   = (widx == WA'(OFF_RXDATA >> 2));
    assign is_ien  = (widx == WA'(OFF_IRQ_EN >> 2));
    assign is_ist  = (widx == WA'(OFF_IRQ_STAT >> 2));

    assign wr_tx     = is_tx & pwrite;
    assign rd_rx     = is_rx & !pwrite;
    assign wr_ctrl   = is_ctrl & pwrite;
    assign wsize_bad = wr_ctrl & (pwdata[3:2] == 2'b11);
    assign dec_err   = !(is_ctrl | is_ien | is_ist | (is_stat & !pwrite) | wr_tx | rd_rx);
    assign err_cond  = dec_err | (wr_tx & !tx_ready) | (rd_rx & !rx_valid) | wsize_bad;
    assign stall     = wr_tx & !tx_ready & (STALL_ON_FULL != 0);

    apb_slave_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .stall    (stall),
        .tx_ready (tx_ready),
        .pready   (done)
    );

    assign pready  = done;
    assign pslverr = done & err_cond;
    assign ok      = done & !err_cond;
    assign wr_ok   = ok & pwrite;
    assign rd_ok   = ok & !pwrite;
    // CTRL still takes its other fields when the word-size code is reserved
    assign ctrl_we = done & wr_ctrl;

    assign tx_valid = ok & wr_tx;
    assign tx_data  = tx_valid ? pwdata : '0;
    assign rx_ready = ok & rd_rx;
    assign soft_rst = ctrl_we & pwdata[12];

    always_comb begin
        prdata = '0;
        if (rd_ok) begin
            if (is_ctrl)      prdata = DW'(ctrl_q);
            else if (is_stat) prdata = DW'({rx_valid, tx_ready});
            else if (is_rx)   prdata = rx_data;
            else if (is_ien)  prdata = DW'(irq_en_q);
            else if (is_ist)  prdata = DW'(irq_stat_q);
        end
    end

    always_comb begin
        ctrl_nxt          = ctrl_t'(pwdata[12:0]);
        ctrl_nxt.soft_rst = 1'b0;
        if (wsize_bad) ctrl_nxt.wsize = ctrl_q.wsize;
    end

    always_comb begin
        irq_set               = '0;
        irq_set[IRQ_TX_OVER]  = done & wr_tx & !tx_ready;
        irq_set[IRQ_RX_UNDER] = done & rd_rx & !rx_valid;
        irq_set[IRQ_RX_AVAIL] = rx_valid & !rx_valid_q;
        irq_clr               = (wr_ok & is_ist) ? pwdata[IRQ_W-1:0] : '0;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            ctrl_q     <= ctrl_t'('0);
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            rx_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            // set is applied after clear so a coincident event is never lost
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
            irq_q      <= |(irq_stat_q & irq_en_q);
            if (ctrl_we) ctrl_q <= ctrl_nxt;
            if (wr_ok && is_ien) irq_en_q <= pwdata[IRQ_W-1:0];
        end
    end

    assign irq  = irq_q & !preset;
    assign ctrl = preset ? ctrl_t'('0) : ctrl_q;

endmodule

// File: tb/tb_i2s_apb_regs.sv
// Scoreboard bench for i2s_apb_regs: directed register scenarios plus randomized APB traffic.
module tb_i2s_apb_regs;

    localparam int DW      = 32;
    localparam int AW      = 8;
    localparam int TIMEOUT = 16;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [12:0]   ctrl;
    logic          soft_rst;
    logic          irq;
    logic          any_out;

    i2s_apb_regs #(
        .DW (DW), .AW (AW), .STALL_ON_FULL (1), .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk (pclk), .preset (preset), .psel (psel), .penable (penable),
        .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .prdata (prdata),
        .pready (pready), .pslverr (pslverr), .tx_data (tx_data), .tx_valid (tx_valid),
        .tx_ready (tx_ready), .rx_data (rx_data), .rx_valid (rx_valid), .rx_ready (rx_ready),
        .ctrl (ctrl), .soft_rst (soft_rst), .irq (irq)
    );

    always #5 pclk = ~pclk;

    assign any_out = |{prdata, pready, pslverr, tx_data, tx_valid, rx_ready, ctrl, soft_rst, irq};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          waits;
        bit          push;
        logic [31:0] tdata;
        bit          pop;
        bit          srst;
    } exp_t;

    exp_t q[$];

    // reference register state
    logic [12:0] m_ctrl = '0;
    logic [2:0]  m_ien  = '0;
    logic [2:0]  m_ist  = '0;

    task automatic model(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                         input int ready_at, output exp_t e);
        e.rdata = '0; e.err = 0; e.waits = 0; e.push = 0; e.tdata = '0; e.pop = 0; e.srst = 0;
        case (addr[7:2])
            6'h00: if (wr) begin
                       e.err  = (wd[3:2] == 2'b11);
                       m_ctrl = {1'b0, wd[11:4], (e.err ? m_ctrl[3:2] : wd[3:2]), wd[1:0]};
                       e.srst = wd[12];
                   end else e.rdata = {19'd0, m_ctrl};
            6'h01: if (wr) e.err = 1; else e.rdata = {30'd0, rx_valid, tx_ready};
            6'h02: if (!wr) e.err = 1;
                   else if (tx_ready) begin e.push = 1; e.tdata = wd; end
                   else if (ready_at >= 1 && ready_at <= TIMEOUT) begin
                       e.push = 1; e.tdata = wd; e.waits = ready_at;
                   end else begin
                       e.err = 1; e.waits = TIMEOUT; m_ist[0] = 1'b1;
                   end
            6'h03: if (wr) e.err = 1;
                   else if (rx_valid) begin e.rdata = rx_data; e.pop = 1; end
                   else begin e.err = 1; m_ist[1] = 1'b1; end
            6'h04: if (wr) m_ien = wd[2:0]; else e.rdata = {29'd0, m_ien};
            6'h05: if (wr) m_ist = m_ist & ~wd[2:0]; else e.rdata = {29'd0, m_ist};
            default: e.err = 1;
        endcase
    endtask

    task automatic set_env(input bit txr, input bit rxv, input logic [31:0] rxd);
        if (rxv && !rx_valid) m_ist[2] = 1'b1;
        tx_ready = txr;
        rx_valid = rxv;
        rx_data  = rxd;
    endtask

    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wd, input int ready_at);
        exp_t e;
        int   n;
        model(wr, addr, wd, ready_at, e);
        q.push_back(e);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1;
        n = 0;
        forever begin
            #1;
            if (pready) break;
            @(posedge pclk); #1;
            n++;
            if (ready_at > 0 && n == ready_at) tx_ready = 1'b1;
            if (n > 64) begin
                checks++; errors++;
                $display("FAIL pready_timeout: got no pready after %0d cycles, expected completion", n);
                break;
            end
        end
        @(posedge pclk); #1;
        psel = 0; penable = 0;
        @(posedge pclk); #1;
        check("irq", {31'd0, irq}, {31'd0, |(m_ist & m_ien)});
        check("ctrl_out", {19'd0, ctrl}, {19'd0, m_ctrl});
    endtask

    // monitor: pops one expectation per completed transfer
    int   waits_seen = 0;
    int   stray = 0;
    exp_t mon_e;

    always @(negedge pclk) begin
        if (preset) begin
            waits_seen = 0;
        end else if (psel && penable && pready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pready: got pready with no pending transfer, expected none");
            end else begin
                mon_e = q.pop_front();
                check("prdata", prdata, mon_e.rdata);
                check("pslverr", {31'd0, pslverr}, {31'd0, mon_e.err});
                check("wait_states", waits_seen, mon_e.waits);
                check("tx_valid", {31'd0, tx_valid}, {31'd0, mon_e.push});
                if (mon_e.push) check("tx_data", tx_data, mon_e.tdata);
                check("rx_ready", {31'd0, rx_ready}, {31'd0, mon_e.pop});
                check("soft_rst", {31'd0, soft_rst}, {31'd0, mon_e.srst});
            end
            waits_seen = 0;
        end else begin
            if (psel && penable) waits_seen++;
            if (tx_valid || rx_ready || soft_rst || pslverr || prdata != '0) stray++;
        end
    end

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        check("outputs_in_reset", {31'd0, any_out}, 32'd0);
        preset = 0;
        #1;
        check("outputs_after_release", {31'd0, any_out}, 32'd0);

        // CTRL write/readback and reset values
        set_env(1'b1, 1'b0, 32'h0);
        xfer(0, 8'h00, 32'h0, 0);
        xfer(0, 8'h14, 32'h0, 0);
        xfer(1, 8'h00, 32'h0000_0125, 0);
        xfer(0, 8'h00, 32'h0, 0);

        // stalled TXDATA write released on wait cycle 5
        set_env(1'b0, 1'b0, 32'h0);
        xfer(1, 8'h08, 32'h0000_A5A5, 5);

        // stalled TXDATA write that times out
        xfer(1, 8'h10, 32'h1, 0);
        set_env(1'b0, 1'b0, 32'h0);
        xfer(1, 8'h08, 32'h0000_1234, 20);
        xfer(0, 8'h14, 32'h0, 0);

        // RX underflow and W1C
        set_env(1'b1, 1'b0, 32'h0);
        xfer(1, 8'h14, 32'h7, 0);
        xfer(0, 8'h0C, 32'h0, 0);
        xfer(0, 8'h14, 32'h0, 0);
        xfer(1, 8'h14, 32'h2, 0);
        xfer(0, 8'h14, 32'h0, 0);

        // soft reset pulse, unmapped access, illegal ops, reserved word size
        xfer(1, 8'h00, 32'h0000_1125, 0);
        xfer(0, 8'h00, 32'h0, 0);
        xfer(1, 8'h3C, 32'hFFFF_FFFF, 0);
        xfer(0, 8'h00, 32'h0, 0);
        xfer(0, 8'h10, 32'h0, 0);
        xfer(1, 8'h00, 32'h0000_012D, 0);
        xfer(0, 8'h00, 32'h0, 0);
        xfer(1, 8'h04, 32'hFFFF_FFFF, 0);
        xfer(0, 8'h08, 32'h0, 0);
        xfer(1, 8'h10, 32'hFFFF_FFF8, 0);
        xfer(0, 8'h10, 32'h0, 0);

        // RX pop and RX_AVAIL edge
        set_env(1'b1, 1'b1, 32'hDEAD_BEEF);
        xfer(0, 8'h0C, 32'h0, 0);
        xfer(0, 8'h14, 32'h0, 0);

        // reset arriving during a stalled TXDATA write
        set_env(1'b0, 1'b0, 32'h0);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = 8'h08; pwdata = 32'h0BAD_0BAD;
        @(posedge pclk); #1;
        penable = 1;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1;
        #1;
        check("outputs_reset_mid_wait", {31'd0, any_out}, 32'd0);
        tx_ready = 1'b1;
        #1;
        check("no_push_in_reset", {31'd0, any_out}, 32'd0);
        @(posedge pclk); #1;
        psel = 0; penable = 0;
        @(posedge pclk); #1;
        preset = 0;
        m_ctrl = '0; m_ien = '0; m_ist = '0;
        #1;
        check("outputs_after_mid_wait_reset", {31'd0, any_out}, 32'd0);
        xfer(0, 8'h00, 32'h0, 0);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            bit          wr;
            int          idx;
            int          ra;
            logic [7:0]  a;
            logic [31:0] d;
            wr  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 7));
            d   = $urandom;
            ra  = 0;
            a   = (idx == 7) ? 8'h3C : 8'(idx * 4);
            a   = a | 8'($urandom_range(0, 3));
            if (idx == 0 && wr && d[3:2] == 2'b11) d[3] = 1'b0;
            set_env(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), $urandom);
            if (idx == 2 && wr && !tx_ready) ra = int'($urandom_range(1, 20));
            xfer(wr, a, d, ra);
        end

        repeat (5) @(posedge pclk);
        #1;
        check("queue_drained", q.size(), 0);
        check("stray_strobes", stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_apb_regs.md
I2S_APB_REGS -- requirements
Module: i2s_apb_regs

Interface
REQ-001 Parameter DW, default 32, SHALL set the width of the APB data bus and the Tx/Rx data paths (legal values 16..32).
REQ-002 Parameter AW, default 8, SHALL set the APB address width (legal values 5 or more).
REQ-003 Parameter STALL_ON_FULL, default 1, SHALL select the TXDATA-write-while-full policy: 1 = wait states, 0 = immediate error.
REQ-004 Parameter TIMEOUT, default 16, SHALL set the maximum number of wait cycles for a stalled TXDATA write.
REQ-005 Clocking and reset SHALL be: one clock, pclk; reset preset, synchronous and active-high.
REQ-006 Ports SHALL be as follows, clock and reset first:
- pclk, in, 1: clock.
- preset, in, 1: sync active-high reset.
- psel, in, 1: APB select.
- penable, in, 1: APB access phase.
- pwrite, in, 1: 1 = write.
- paddr, in, AW: byte address.
- pwdata, in, DW: write data.
- prdata, out, DW: read data.
- pready, out, 1: transfer complete.
- pslverr, out, 1: transfer error, valid only with pready.
- tx_data, out, DW: word to Tx FIFO.
- tx_valid, out, 1: tx_data valid.
- tx_ready, in, 1: Tx FIFO can accept.
- rx_data, in, DW: Rx FIFO head.
- rx_valid, in, 1: Rx FIFO non-empty.
- rx_ready, out, 1: pop Rx FIFO.
- ctrl, out, 13: packed control struct.
- soft_rst, out, 1: one-cycle core reset pulse.
- irq, out, 1: interrupt.

Function
REQ-007 The register map (word-aligned, paddr[AW-1:2]) SHALL be: 0x00 CTRL RW; 0x04 STATUS RO {rx_valid, tx_ready}; 0x08 TXDATA WO; 0x0C RXDATA RO; 0x10 IRQ_EN RW[2:0]; 0x14 IRQ_STAT W1C[2:0].
REQ-008 CTRL fields SHALL be: [0] stereo; [1] rate (0 = 44.1k, 1 = 48k); [3:2] word size (16/24/32, 3 reserved); [4] frame (16/32); [5] mclk_en; [7:6] standard (I2S/MSB/LSB); [9:8] mode (ST/SR/MT/MR); [10] mute; [11] stop; [12] soft reset.
REQ-009 The APB FSM SHALL have states IDLE, ACCESS and WAIT: IDLE -> ACCESS on psel & !penable; ACCESS -> IDLE with pready = 1 in the same cycle unless a stall applies; ACCESS -> WAIT on a stall; WAIT -> IDLE with pready = 1 when tx_ready = 1 or the timeout expires.
REQ-010 Non-stalled accesses SHALL complete with zero wait states, i.e. pready = 1 in the first penable cycle.
REQ-011 prdata SHALL be valid in the pready cycle and SHALL read 0 in every other cycle.
REQ-012 A TXDATA write with tx_ready = 1 SHALL assert tx_valid for exactly one cycle with tx_data = pwdata.
REQ-013 A TXDATA write with tx_ready = 0 and STALL_ON_FULL = 1 SHALL hold pready = 0 and load the wait counter.
- If tx_ready rises within TIMEOUT cycles, the push occurs and pslverr = 0.
- Otherwise pslverr = 1, no push occurs, and IRQ_STAT[0] (TX_OVER) is set.
REQ-014 A TXDATA write with tx_ready = 0 and STALL_ON_FULL = 0 SHALL complete immediately with pslverr = 1 and set TX_OVER.
REQ-015 An RXDATA read with rx_valid = 1 SHALL return rx_data and pulse rx_ready for one cycle.
REQ-016 An RXDATA read with rx_valid = 0 SHALL return 0 with pslverr = 1 and set IRQ_STAT[1] (RX_UNDER).
REQ-017 IRQ_STAT[2] (RX_AVAIL) SHALL set on each 0 -> 1 edge of rx_valid.
REQ-018 IRQ_STAT bits SHALL be sticky and cleared by writing 1; if a set and a clear hit the same bit in the same cycle, the set wins.
REQ-019 irq SHALL be registered as |(IRQ_STAT & IRQ_EN), one cycle after the flag change.
REQ-020 Writing CTRL[12] = 1 SHALL pulse soft_rst for one cycle; CTRL[12] SHALL self-clear and always read 0.
REQ-021 An unmapped address, a write to STATUS/RXDATA, or a read of TXDATA SHALL complete with pslverr = 1, prdata = 0 and no state change.
REQ-022 Writing word-size code 3 SHALL keep the previous word-size field value, and the access SHALL complete with pslverr = 1.
REQ-023 Writing pwdata bits above a register's defined width SHALL have no effect, and those bits SHALL read as 0.

Reset
REQ-024 While preset = 1, all registers, flags, the FSM (to IDLE) and the wait counter SHALL clear.
REQ-025 While preset = 1 and in the cycle after its release, all outputs SHALL be 0.
REQ-026 A preset arriving mid-WAIT SHALL abort the transfer with no push and no pslverr.
REQ-027 soft_rst SHALL NOT clear this block's own registers.

Structure
REQ-028 Package i2s_pkg SHALL hold the ctrl_t packed struct, the enums (rate_e, wsize_e, fsize_e, std_e, mode_e), the register offset constants and the IRQ bit indices.
REQ-029 The APB FSM and wait counter SHALL be a sub-module, apb_slave_fsm; decode and storage remain in i2s_apb_regs.

Verification
REQ-030 After reset, write CTRL = 0x0000_0125 then read it -> prdata = 0x125 and ctrl = 0x125, both with zero wait states.
REQ-031 With tx_ready = 0 and STALL_ON_FULL = 1, write TXDATA = 0xA5A5 and raise tx_ready on wait cycle 5 -> pready after 5 waits, pslverr = 0, one tx_valid pulse carrying 0xA5A5.
REQ-032 Hold tx_ready = 0 for 20 cycles during a TXDATA write -> pslverr = 1 at wait cycle 16, no tx_valid, IRQ_STAT = 0x1, and irq = 1 if IRQ_EN[0] = 1.
REQ-033 Read RXDATA with rx_valid = 0 -> prdata = 0, pslverr = 1, IRQ_STAT[1] = 1; then write IRQ_STAT = 0x2 -> it reads 0.
REQ-034 Write CTRL[12] = 1 -> soft_rst high for exactly one cycle and CTRL reads bit 12 = 0; then write to 0x3C -> pslverr = 1 and no register changes.
